nibble_serial_adder_ctrl: RTL and testbench

Sequencing controller that computes a WIDTH-bit sum by time-multiplexing one existing 4-bit ripple-carry adder (rca4) over WIDTH/4 clock cycles, one nibble per cycle, least-significant nibble first. The carry is registered between nibbles. A start/busy/done handshake exposes the block to the surrounding lab datapath, which trades latency for area compared with a full-width combinational adder.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_rca4.sv | 24 ++
 rtl/nibble_serial_adder_ctrl.sv | 88 ++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared state encoding and nibble width
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// rtl/nibble_serial_adder_ctrl_rca4.sv - 4-bit ripple-carry adder datapath
module nibble_serial_adder_ctrl_rca4
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  // one full adder per bit, carry rippling upward
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit adder sequenced one nibble per cycle over a shared rca4
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB);

  state_t              state;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  // the single shared nibble adder works on the low nibbles of the shift registers
  nibble_serial_adder_ctrl_rca4 u_rca4 (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // sequencer: capture operands, step one nibble per edge, pulse done at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= {nib_sum, sum[WIDTH-1:NIBBLE_W]};
          carry <= nib_cout;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NIB - 1)) begin
            cout  <= nib_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for WIDTH 16, 8 and 32 instances
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        rst16, st16, c16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        rst8, st8, c8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        rst32, st32, c32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16), .start(st16), .a(a16), .b(b16), .cin(c16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));
  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8), .start(st8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst32), .start(st32), .a(a32), .b(b32), .cin(c32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

  // ---------------- scoreboards ----------------
  logic [16:0] q16[$];
  logic [8:0]  q8[$];
  logic [32:0] q32[$];
  logic [16:0] e16;
  logic [8:0]  e8;
  logic [32:0] e32;
  int ndone16 = 0;
  bit fin8 = 0, fin32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: plain unsigned addition, result bit WIDTH is the carry out
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 9'(c);
  endfunction
  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 33'(c);
  endfunction

  // monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst16 && done16) begin
      ndone16++;
      chk("busy_with_done16", 64'(busy16), 64'(0));
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done16 actual=%h required=none", {cout16, sum16});
      end else begin
        e16 = q16.pop_front();
        chk("result16", 64'({cout16, sum16}), 64'(e16));
      end
    end
  end

  always @(negedge clk) begin
    if (rst8 && done8) begin
      chk("busy_with_done8", 64'(busy8), 64'(0));
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done8 actual=%h required=none", {cout8, sum8});
      end else begin
        e8 = q8.pop_front();
        chk("result8", 64'({cout8, sum8}), 64'(e8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst32 && done32) begin
      chk("busy_with_done32", 64'(busy32), 64'(0));
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done32 actual=%h required=none", {cout32, sum32});
      end else begin
        e32 = q32.pop_front();
        chk("result32", 64'({cout32, sum32}), 64'(e32));
      end
    end
  end

  // ---------------- helpers for the 16-bit instance ----------------
  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic c, output int t);
    a16 = x; b16 = y; c16 = c; st16 = 1'b1;
    q16.push_back(ref16(x, y, c));
    @(posedge clk); #1;
    t = cyc;
    st16 = 1'b0;
  endtask

  task automatic wait_done16(output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done16) begin
        dc = cyc;
        return;
      end
    end
    total++; bad++;
    $display("FAIL timeout_done16 actual=no_done required=done");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  // ---------------- 16-bit directed + random, then summary ----------------
  initial begin
    int t, d1, d2, saved, n;
    rst16 = 1'b0; st16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state16", 64'({busy16, done16, cout16, sum16}), 64'(0));
    @(negedge clk) rst16 = 1'b1;
    @(posedge clk); #1;

    // basic op and latency
    issue16(16'h1234, 16'h4321, 1'b0, t);
    chk("busy_after_start16", 64'(busy16), 64'(1));
    wait_done16(d1);
    chk("latency16", 64'(d1 - t), 64'(4));
    @(posedge clk); #1;

    // held start: new operands during RUN ignored, accepted back-to-back in DONE
    a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b0; st16 = 1'b1;
    q16.push_back(ref16(16'h1234, 16'h4321, 1'b0));
    @(posedge clk); #1;
    t = cyc;
    a16 = 16'h0F0F; b16 = 16'h00F1;
    q16.push_back(ref16(16'h0F0F, 16'h00F1, 1'b0));
    wait_done16(d1);
    chk("b2b_latency16", 64'(d1 - t), 64'(4));
    @(posedge clk); #1;
    st16 = 1'b0;
    wait_done16(d2);
    chk("b2b_spacing16", 64'(d2 - d1), 64'(5));
    @(posedge clk); #1;

    // carry rippling through every nibble
    issue16(16'hFFFF, 16'h0001, 1'b0, t);
    wait_done16(d1);
    @(posedge clk); #1;
    issue16(16'hFFFF, 16'h0000, 1'b1, t);
    wait_done16(d1);
    @(posedge clk); #1;

    // async reset in the second RUN cycle aborts without a done pulse
    saved = ndone16;
    issue16(16'h1234, 16'h4321, 1'b0, t);
    @(posedge clk); #1;
    rst16 = 1'b0;
    #1;
    chk("async_reset16", 64'({busy16, done16, cout16, sum16}), 64'(0));
    q16.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst16 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_done_after_abort16", 64'(ndone16), 64'(saved));
    issue16(16'hA5C3, 16'h3C5A, 1'b1, t);
    wait_done16(d1);
    chk("latency_after_reset16", 64'(d1 - t), 64'(4));
    @(posedge clk); #1;

    // random regression; start toggled randomly while busy must be ignored
    n = 0;
    while (n < 1000) begin
      if (!busy16 && $urandom_range(0, 3) != 0) begin
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        st16 = 1'b1;
        q16.push_back(ref16(a16, b16, c16));
        n++;
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        st16 = busy16 ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
    end
    st16 = 1'b0;
    for (int i = 0; i < 40 && q16.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain16", 64'(q16.size()), 64'(0));

    for (int i = 0; i < 20000 && !(fin8 && fin32); i++) @(posedge clk);
    chk("others_finished", 64'({fin8, fin32}), 64'(2'b11));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- 8-bit instance ----------------
  initial begin
    int t, n;
    bit seen;
    rst8 = 1'b0; st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state8", 64'({busy8, done8, cout8, sum8}), 64'(0));
    @(negedge clk) rst8 = 1'b1;
    @(posedge clk); #1;

    a8 = 8'h9C; b8 = 8'h7A; c8 = 1'b1; st8 = 1'b1;
    q8.push_back(ref8(8'h9C, 8'h7A, 1'b1));
    @(posedge clk); #1;
    t = cyc;
    st8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1;
        chk("latency8", 64'(cyc - t), 64'(2));
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout_done8 actual=no_done required=done");
    end
    @(posedge clk); #1;

    n = 0;
    while (n < 300) begin
      if (!busy8 && $urandom_range(0, 3) != 0) begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        st8 = 1'b1;
        q8.push_back(ref8(a8, b8, c8));
        n++;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        st8 = busy8 ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
    end
    st8 = 1'b0;
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain8", 64'(q8.size()), 64'(0));
    fin8 = 1;
  end

  // ---------------- 32-bit instance ----------------
  initial begin
    int n;
    rst32 = 1'b0; st32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state32", 64'({busy32, done32, cout32, sum32}), 64'(0));
    @(negedge clk) rst32 = 1'b1;
    @(posedge clk); #1;

    n = 0;
    while (n < 1000) begin
      if (!busy32 && $urandom_range(0, 3) != 0) begin
        a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          a32 = 32'hFFFF_FFFF;
          b32 = 32'($urandom_range(0, 1));
        end
        st32 = 1'b1;
        q32.push_back(ref32(a32, b32, c32));
        n++;
      end else begin
        a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
        st32 = busy32 ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
    end
    st32 = 1'b0;
    for (int i = 0; i < 40 && q32.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain32", 64'(q32.size()), 64'(0));
    fin32 = 1;
  end

endmodule
